// File: rtl/io_responder_if.sv
// CPU-side I/O strobe bus between the datapath and the I/O responder.
// The CPU stalls on io_busy and completes on the io_ready pulse.
interface io_responder_if;
    logic        io_read;
    logic        io_write;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;
    logic        io_ready;
    logic        io_busy;

    modport master (
        output io_read,
        output io_write,
        output io_wdata,
        input  io_rdata,
        input  io_ready,
        input  io_busy
    );

    modport slave (
        input  io_read,
        input  io_write,
        input  io_wdata,
        output io_rdata,
        output io_ready,
        output io_busy
    );
endinterface

// File: rtl/io_responder.sv
// Single-address I/O responder: LED writes complete at once, switch
// reads wait for a debounced button press made during the read.
module io_responder #(
    parameter int SW_WIDTH        = 16,
    parameter int LED_WIDTH       = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    io_responder_if.slave        bus,
    input  logic [SW_WIDTH-1:0]  sw_raw,
    input  logic                 btn_raw,
    output logic [LED_WIDTH-1:0] led
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BTN,
        RD_DONE,
        WR_DONE
    } state_e;

    state_e state_q, state_d;

    logic [SW_WIDTH-1:0]  sw_s1_q, sw_s_q;
    logic                 btn_s1_q, btn_s_q;
    logic                 db_q, db_d;
    logic                 db_prev_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [LED_WIDTH-1:0] led_q, led_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 ready_q, ready_d;
    logic                 press;
    logic                 unused_wdata;

    assign unused_wdata = ^bus.io_wdata[31:LED_WIDTH];

    // Board inputs are asynchronous; two flops before any use.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_s1_q  <= '0;
            sw_s_q   <= '0;
            btn_s1_q <= 1'b0;
            btn_s_q  <= 1'b0;
        end else begin
            sw_s1_q  <= sw_raw;
            sw_s_q   <= sw_s1_q;
            btn_s1_q <= btn_raw;
            btn_s_q  <= btn_s1_q;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        if (btn_s_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            db_d  = btn_s_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign press = db_q & ~db_prev_q;

    always_comb begin
        state_d = state_q;
        led_d   = led_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (bus.io_write) begin
                    led_d   = bus.io_wdata[LED_WIDTH-1:0];
                    state_d = WR_DONE;
                end else if (bus.io_read) begin
                    state_d = WAIT_BTN;
                end
            end
            WAIT_BTN: begin
                if (!bus.io_read) begin
                    state_d = IDLE;
                end else if (press) begin
                    rdata_d = 32'(sw_s_q);
                    state_d = RD_DONE;
                end
            end
            RD_DONE: state_d = IDLE;
            WR_DONE: state_d = IDLE;
        endcase
        ready_d = (state_d == RD_DONE) || (state_d == WR_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            cnt_q     <= '0;
            led_q     <= '0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            db_q      <= db_d;
            db_prev_q <= db_q;
            cnt_q     <= cnt_d;
            led_q     <= led_d;
            rdata_q   <= rdata_d;
            ready_q   <= ready_d;
        end
    end

    assign led          = led_q;
    assign bus.io_rdata = rdata_q;
    assign bus.io_ready = ready_q;
    assign bus.io_busy  = (bus.io_read | bus.io_write) & ~ready_q;

endmodule

// File: tb/tb_io_responder.sv
// Scoreboard bench for io_responder: drivers queue expected completions,
// a negedge monitor checks every io_ready pulse and the busy equation.
module tb_io_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] sw_raw = 16'hFFFF;
    logic        btn_raw = 1'b0;
    logic [15:0] led;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        bit          wr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];

    io_responder_if bus ();

    io_responder #(
        .SW_WIDTH(16),
        .LED_WIDTH(16),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .sw_raw(sw_raw),
        .btn_raw(btn_raw),
        .led(led)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: busy equation every cycle, completions against the queue.
    always @(negedge clk) begin
        checks++;
        if (bus.io_busy !== ((bus.io_read | bus.io_write) & ~bus.io_ready)) begin
            errors++;
            $display("FAIL busy_eq: cyc=%0d io_busy=%b", cyc, bus.io_busy);
        end
        if (bus.io_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ready: cyc=%0d got io_ready=1, required 0", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.cyc != cyc) begin
                    errors++;
                    $display("FAIL ready_cycle: got cyc=%0d, required cyc=%0d", cyc, e.cyc);
                end
                checks++;
                if (e.wr && led !== e.data[15:0]) begin
                    errors++;
                    $display("FAIL wr_led: got %h, required %h", led, e.data[15:0]);
                end else if (!e.wr && bus.io_rdata !== e.data) begin
                    errors++;
                    $display("FAIL rd_data: got %h, required %h", bus.io_rdata, e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(posedge clk);
            #1;
            if (bus.io_ready === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ready_timeout: io_ready=0 after %0d cycles, required 1", budget);
        end
    endtask

    task automatic do_write(input logic [31:0] wdata, input bit also_read);
        step(1);
        bus.io_write = 1'b1;
        bus.io_read  = also_read;
        bus.io_wdata = wdata;
        exp_q.push_back('{wr: 1'b1, data: wdata, cyc: cyc + 1});
        wait_ready(5);
        bus.io_write = 1'b0;
        bus.io_read  = 1'b0;
    endtask

    // Strobe must already be high and the FSM in WAIT_BTN.
    task automatic press_and_complete();
        step(1);
        btn_raw = 1'b1;
        exp_q.push_back('{wr: 1'b0, data: {16'h0, sw_raw}, cyc: cyc + 7});
        wait_ready(20);
        bus.io_read = 1'b0;
        step(2);
        btn_raw = 1'b0;
        step(10);
    endtask

    initial begin
        bus.io_read  = 1'b0;
        bus.io_write = 1'b0;
        bus.io_wdata = '0;

        // Reset with switches all high
        step(3);
        check("rst_led", 32'(led), 32'h0);
        check("rst_rdata", bus.io_rdata, 32'h0);
        check("rst_ready", 32'(bus.io_ready), 32'h0);
        check("rst_busy", 32'(bus.io_busy), 32'h0);
        rst = 1'b0;
        step(2);

        // Write
        do_write(32'h1234ABCD, 1'b0);
        step(3);
        check("led_hold", 32'(led), 32'h0000ABCD);

        // Clean read
        sw_raw = 16'h00A5;
        step(3);
        bus.io_read = 1'b1;
        step(3);
        press_and_complete();
        check("rdata_hold", bus.io_rdata, 32'h000000A5);

        // Bounce: 3-cycle glitch rejected, then a solid hold completes
        sw_raw = 16'h3C3C;
        step(3);
        bus.io_read = 1'b1;
        step(3);
        btn_raw = 1'b1;
        step(3);
        btn_raw = 1'b0;
        step(12);
        check("bounce_no_ready", 32'(bus.io_ready), 32'h0);
        check("bounce_busy", 32'(bus.io_busy), 32'h1);
        press_and_complete();

        // Stale press: button held before the read starts
        sw_raw = 16'hBEEF;
        btn_raw = 1'b1;
        step(12);
        bus.io_read = 1'b1;
        step(12);
        check("stale_no_ready", 32'(bus.io_ready), 32'h0);
        btn_raw = 1'b0;
        step(10);
        press_and_complete();

        // Abort in WAIT_BTN leaves io_rdata alone
        sw_raw = 16'h1111;
        step(3);
        bus.io_read = 1'b1;
        step(4);
        bus.io_read = 1'b0;
        step(6);
        check("abort_rdata", bus.io_rdata, 32'h0000BEEF);
        check("abort_busy", 32'(bus.io_busy), 32'h0);

        // Simultaneous strobes: write wins, no read begins
        do_write(32'hFFFF5A5A, 1'b1);
        step(10);
        check("simul_led", 32'(led), 32'h00005A5A);

        // Reset mid-read, then the same read completes normally
        sw_raw = 16'h0F0F;
        step(3);
        bus.io_read = 1'b1;
        step(4);
        rst = 1'b1;
        step(1);
        check("mid_rst_led", 32'(led), 32'h0);
        check("mid_rst_rdata", bus.io_rdata, 32'h0);
        check("mid_rst_ready", 32'(bus.io_ready), 32'h0);
        rst = 1'b0;
        step(4);
        press_and_complete();

        step(5);
        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
